mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported unified instruction/data memory of the multicycle CPU between two requesters.
//  - Requester 0: the CPU, i.e. the controller's MemRead/MemWrite, with the address selected by IorD.
//  - Requester 1: the program-loader/DMA port.
//  Sequences each access over a variable-latency req/ack memory handshake; a watchdog aborts hung accesses.
//  The controller holds its FSM state (stall) while cpu_req=1 and cpu_ready=0.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width
//  TIMEOUT     15  max cycles in BUSY waiting for mem_ack before abort (>=1)
//  STARVE_MAX   4  consecutive CPU wins over a pending DMA request before DMA is forced
// PORTS
//  Clk        in   1       clock; all state on posedge
//  Rst        in   1       synchronous, active-high reset
//  cpu_req    in   1       CPU access request (MemRead|MemWrite); held until cpu_ready
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  byte address
//  cpu_wdata  in   DATA_W  write data
//  cpu_ready  out  1       one-cycle completion pulse
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
//  dma_req    in   1       loader request; held until dma_ready
//  dma_we     in   1       1=write, 0=read
//  dma_addr   in   ADDR_W  byte address
//  dma_wdata  in   DATA_W  write data
//  dma_ready  out  1       one-cycle completion pulse
//  dma_rdata  out  DATA_W  read data, valid while dma_ready=1
//  mem_req    out  1       memory request; held high until mem_ack
//  mem_we     out  1       memory write enable (registered copy of owner's we)
//  mem_addr   out  ADDR_W  registered address
//  mem_wdata  out  DATA_W  registered write data
//  mem_ack    in   1       memory done; sampled only while mem_req=1
//  mem_rdata  in   DATA_W  read data, valid with mem_ack
//  err        out  1       one-cycle pulse with *_ready when the access timed out
// BEHAVIOUR
//  Reset: state=IDLE, owner=CPU.
//    - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, cpu/dma_ready, cpu/dma_rdata, err.
//    - starve_cnt=0, wd_cnt=0.
//    - Rst during BUSY drops mem_req the next cycle, no ready is issued, and memory must tolerate the abandoned request.
//  All outputs are registered.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE
//    - No request: stay.
//    - Only one request: grant it.
//    - Both requesting: grant CPU unless starve_cnt==STARVE_MAX, then grant DMA.
//    - On a grant: latch owner, we, addr and wdata into mem_*; set mem_req=1; wd_cnt=0; go to BUSY.
//  BUSY
//    - mem_req held high; mem_* stay stable regardless of requester inputs.
//    - mem_ack=1: capture mem_rdata (or 0 for a write); mem_req=0; go to RESP.
//    - Else wd_cnt++. When wd_cnt==TIMEOUT-1 without ack: mem_req=0, rdata=0, set err flag, go to RESP.
//  RESP
//    - Owner's *_ready=1 and *_rdata valid for exactly this cycle; err=1 only after a timeout.
//    - The other ready stays 0. Go to IDLE; rdata returns to 0 in IDLE.
//  Starvation
//    - starve_cnt++ (saturating at STARVE_MAX) on each CPU grant made while dma_req=1.
//    - Cleared on any DMA grant, and on a CPU grant made while dma_req=0.
//  Latency
//    - Request seen in IDLE at cycle t; mem_req=1 in t+1.
//    - mem_ack in cycle t+k (k>=1) gives ready in t+k+1.
//    - Minimum is 3 cycles from grant-sampling IDLE to ready.
//  Requesters drop req (or present a new access) on the edge that ends the ready cycle.
//  The IDLE after RESP guarantees no re-grant of a stale req.
//  mem_ack outside BUSY is ignored. A request dropped early while BUSY still completes and still pulses ready.
//  Reads and writes follow identical timing.
// STRUCTURE
//  Package mem_arb_pkg:
//    - state encoding IDLE=2'b00, BUSY=2'b01, RESP=2'b10
//    - owner encoding OWN_CPU=1'b0, OWN_DMA=1'b1
//  Sub-module mem_arb_watchdog: wd_cnt counter with clear/enable/expired, sized $clog2(TIMEOUT)+1.
//  FSM, arbitration and output registers stay in mem_port_arbiter.
// TESTING
//  1. CPU read 0x40 alone, mem_ack 2 cycles after mem_req, mem_rdata=0x8C220004
//     -> mem_addr=0x40, mem_we=0; cpu_ready pulse 1 cycle after ack; cpu_rdata=0x8C220004; dma_ready=0.
//  2. cpu_req and dma_req high continuously, mem_ack immediate
//     -> grant order CPU x4, DMA, CPU x4, DMA...; no requester starved.
//  3. DMA write 0x100<=0xDEADBEEF, never ack
//     -> mem_req falls after TIMEOUT=15 BUSY cycles; dma_ready=1 and err=1 same cycle; next access proceeds normally.
//  4. Rst asserted on 3rd BUSY cycle of a CPU read
//     -> next cycle mem_req=0, all outputs 0, no cpu_ready; a later request starts from IDLE.
//  5. cpu_addr/cpu_wdata changed while BUSY
//     -> mem_addr/mem_wdata hold the latched values until RESP.
//  6. Spurious mem_ack in IDLE
//     -> no ready, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tags
// and the grant-selection rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // The CPU wins ties unless the loader has already lost too many times in a row.
  function automatic logic pick_dma(input logic cpu_req, input logic dma_req,
                                    input logic starved);
    return dma_req && (!cpu_req || starved);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for a pending memory access. It raises expired once the
// access has waited TIMEOUT-1 cycles without being acknowledged.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (enable) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign expired = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported instruction/data memory between the CPU and the
// loader/DMA port. Each access runs IDLE -> BUSY -> RESP, and every output is registered.
// Handshake: a requester holds *_req and its access fields until its *_ready pulse.
// mem_req stays high until mem_ack, which is sampled only while in BUSY.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                dma_ready_q, dma_ready_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                err_q, err_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starved, grant_dma;
  logic                wd_clear, wd_enable, wd_expired;
  logic [DATA_W-1:0]   rdata_sel;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    starved     = (starve_q == STARVE_W'(STARVE_MAX));
    grant_dma   = pick_dma(cpu_req, dma_req, starved);
    rdata_sel   = mem_we_q ? '0 : mem_rdata;
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_rdata_d = '0;
    dma_rdata_d = '0;
    err_d       = 1'b0;
    starve_d    = starve_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = BUSY;
          owner_d     = grant_dma ? OWN_DMA : OWN_CPU;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_dma ? dma_we : cpu_we;
          mem_addr_d  = grant_dma ? dma_addr : cpu_addr;
          mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          wd_clear    = 1'b1;
          // Only CPU wins that leave the loader waiting count towards starvation.
          if (grant_dma || !dma_req) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ack || wd_expired) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (owner_q == OWN_DMA) begin
            dma_ready_d = 1'b1;
            dma_rdata_d = mem_ack ? rdata_sel : '0;
          end else begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = mem_ack ? rdata_sel : '0;
          end
        end else begin
          wd_enable = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      err_q       <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// two-requester traffic checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TIMEOUT    = 15;
  localparam int STARVE_MAX = 4;

  logic              Clk, Rst;
  logic              cpu_req, cpu_we, cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_ready;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              mem_req, mem_we, mem_ack, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory responder knobs: ack in the (ack_delay+1)-th cycle of mem_req.
  int                ack_delay;
  int                busy_cyc;
  logic              force_ack;
  logic [DATA_W-1:0] rd_val;
  logic [0:0]        exp_q[$];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock: outputs are sampled 1ns after the edge, then the memory responds.
  task automatic step();
    @(posedge Clk);
    #1;
    if (mem_req) begin
      busy_cyc++;
      mem_ack = (ack_delay >= 0) && (busy_cyc == ack_delay + 1);
    end else begin
      busy_cyc = 0;
      mem_ack  = force_ack;
    end
    mem_rdata = rd_val;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ack = 0; mem_rdata = '0; force_ack = 0; ack_delay = 0; busy_cyc = 0; rd_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Rst = 1; step(); step();
    Rst = 0; step();
  endtask

  // Counts mem_req-high cycles starting from a cycle where it is already high.
  task automatic wait_req_fall(output int n);
    n = 1;
    while (n <= TIMEOUT + 5) begin
      step();
      if (!mem_req) return;
      n++;
    end
  endtask

  task automatic new_cpu();
    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom(); cpu_wdata = $urandom();
  endtask

  task automatic new_dma();
    dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom(); dma_wdata = $urandom();
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst = 1; step(); step();
    tests_run++;
    if ({mem_req, mem_we, cpu_ready, dma_ready, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 00000", {mem_req, mem_we, cpu_ready, dma_ready, err});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_buses: got addr=%h wdata=%h crd=%h drd=%h required all 0", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    end
    Rst = 0; step();
  endtask

  task automatic test_cpu_read();
    int n;
    do_reset();
    ack_delay = 2; rd_val = 32'h8C22_0004;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_wdata = $urandom();
    step();
    tests_run++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      tests_failed++; $display("FAIL read_issue: got req=%b we=%b addr=%h required 1 0 00000040", mem_req, mem_we, mem_addr);
    end
    wait_req_fall(n);
    tests_run++;
    if (n !== 3) begin
      tests_failed++; $display("FAIL read_latency: got %0d busy cycles required 3", n);
    end
    tests_run++;
    if ({cpu_ready, dma_ready, err, cpu_rdata} !== {3'b100, 32'h8C22_0004}) begin
      tests_failed++;
      $display("FAIL read_resp: got rdy=%b dma_rdy=%b err=%b rdata=%h required 1 0 0 8c220004", cpu_ready, dma_ready, err, cpu_rdata);
    end
    cpu_req = 0;
    step();
    tests_run++;
    if ({cpu_ready, cpu_rdata, dbg_state} !== {1'b0, 32'h0, 2'(IDLE)}) begin
      tests_failed++; $display("FAIL read_after: got rdy=%b rdata=%h state=%0d required 0 0 0", cpu_ready, cpu_rdata, dbg_state);
    end
  endtask

  task automatic test_fair_share();
    int cyc;
    logic [0:0] exp;
    do_reset();
    ack_delay = 0;
    cpu_req = 1; cpu_addr = 32'h1000; dma_req = 1; dma_addr = 32'h2000;
    for (int i = 0; i < 15; i++) exp_q.push_back((i % 5 == 4) ? 1'b1 : 1'b0);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      step(); cyc++;
      if (cpu_ready || dma_ready) begin
        exp = exp_q.pop_front();
        tests_run++;
        if ({cpu_ready, dma_ready} !== (exp ? 2'b01 : 2'b10)) begin
          tests_failed++; $display("FAIL fair_order: got cpu/dma ready=%b required owner %0d", {cpu_ready, dma_ready}, exp);
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL fair_budget: got %0d grants missing required 0", exp_q.size());
      exp_q.delete();
    end
    cpu_req = 0; dma_req = 0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    ack_delay = 1000;
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hDEAD_BEEF;
    step();
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL to_issue: got req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata);
    end
    wait_req_fall(n);
    tests_run++;
    if (n !== TIMEOUT) begin
      tests_failed++; $display("FAIL to_cycles: got %0d required %0d", n, TIMEOUT);
    end
    tests_run++;
    if ({dma_ready, err, cpu_ready, dma_rdata} !== {3'b110, 32'h0}) begin
      tests_failed++; $display("FAIL to_resp: got dma_rdy=%b err=%b cpu_rdy=%b rdata=%h required 1 1 0 0", dma_ready, err, cpu_ready, dma_rdata);
    end
    dma_req = 0;
    step();
    tests_run++;
    if ({dma_ready, err} !== 2'b00) begin
      tests_failed++; $display("FAIL to_clear: got rdy=%b err=%b required 0 0", dma_ready, err);
    end
    ack_delay = 1; rd_val = 32'h1234_5678;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
    step();
    wait_req_fall(n);
    tests_run++;
    if ({n == 2, cpu_ready, err, cpu_rdata} !== {3'b110, 32'h1234_5678}) begin
      tests_failed++; $display("FAIL to_next: got n=%0d rdy=%b err=%b rdata=%h required 2 1 0 12345678", n, cpu_ready, err, cpu_rdata);
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_reset_busy();
    int n;
    logic seen;
    do_reset();
    ack_delay = 1000;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    step(); step(); step();
    tests_run++;
    if ({mem_req, dbg_state} !== {1'b1, 2'(BUSY)}) begin
      tests_failed++; $display("FAIL rb_busy: got req=%b state=%0d required 1 1", mem_req, dbg_state);
    end
    Rst = 1;
    step();
    tests_run++;
    if ({mem_req, mem_we, cpu_ready, dma_ready, err, mem_addr, cpu_rdata, dbg_state} !== '0) begin
      tests_failed++; $display("FAIL rb_outputs: got req=%b addr=%h rdy=%b state=%0d required all 0", mem_req, mem_addr, cpu_ready, dbg_state);
    end
    Rst = 0; cpu_req = 0; seen = 0;
    repeat (4) begin
      step();
      if (cpu_ready || mem_req) seen = 1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL rb_no_ready: got activity=%b required 0", seen);
    end
    ack_delay = 0; cpu_addr = 32'hC0; cpu_req = 1;
    step();
    tests_run++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hC0}) begin
      tests_failed++; $display("FAIL rb_restart: got req=%b addr=%h required 1 000000c0", mem_req, mem_addr);
    end
    wait_req_fall(n);
    tests_run++;
    if ({n == 1, cpu_ready} !== 2'b11) begin
      tests_failed++; $display("FAIL rb_restart_done: got n=%0d rdy=%b required 1 1", n, cpu_ready);
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_spurious_ack();
    logic seen;
    do_reset();
    force_ack = 1; seen = 0;
    repeat (5) begin
      step();
      if (mem_req || cpu_ready || dma_ready || err || dbg_state !== IDLE) seen = 1;
    end
    force_ack = 0;
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL spurious_ack: got activity=%b required 0", seen);
    end
    step();
  endtask

  task automatic test_random_traffic();
    int                model_starve, n, w, r, exp_n;
    logic              cpu_pend, dma_pend, win_dma, exp_we, exp_to, hold_bad;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_rdata;
    do_reset();
    model_starve = 0; cpu_pend = 0; dma_pend = 0;
    for (int t = 0; t < 60; t++) begin
      if (!cpu_pend && $urandom_range(0, 2) != 0) begin cpu_pend = 1; new_cpu(); end
      if (!dma_pend && $urandom_range(0, 2) != 0) begin dma_pend = 1; new_dma(); end
      if (!cpu_pend && !dma_pend) begin cpu_pend = 1; new_cpu(); end
      cpu_req = cpu_pend; dma_req = dma_pend;
      // Arbitration model: CPU first, loader forced after STARVE_MAX straight losses.
      win_dma   = dma_pend && (!cpu_pend || model_starve == STARVE_MAX);
      exp_addr  = win_dma ? dma_addr : cpu_addr;
      exp_we    = win_dma ? dma_we : cpu_we;
      exp_wdata = win_dma ? dma_wdata : cpu_wdata;
      if (win_dma || !dma_pend) model_starve = 0;
      else if (model_starve < STARVE_MAX) model_starve++;
      r = $urandom_range(0, 9);
      ack_delay = (r < 7) ? $urandom_range(0, 5) : (r == 7) ? TIMEOUT - 1 : 99;
      rd_val    = $urandom();
      exp_to    = (ack_delay > TIMEOUT - 1);
      exp_n     = exp_to ? TIMEOUT : ack_delay + 1;
      exp_rdata = (exp_to || exp_we) ? '0 : rd_val;
      w = 0;
      do begin step(); w++; end while (!mem_req && w < 4);
      tests_run++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, exp_we, exp_addr, exp_wdata}) begin
        tests_failed++;
        $display("FAIL rnd_grant[%0d]: got req=%b we=%b addr=%h wdata=%h required 1 %b %h %h", t, mem_req, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
      end
      n = 1; hold_bad = 0;
      while (n <= TIMEOUT + 4) begin
        // The owner scrambles its inputs and may drop its request mid-access.
        if (win_dma) begin
          new_dma(); if ($urandom_range(0, 3) == 0) dma_req = 0;
        end else begin
          new_cpu(); if ($urandom_range(0, 3) == 0) cpu_req = 0;
        end
        step();
        if (!mem_req) break;
        n++;
        if ({mem_we, mem_addr, mem_wdata} !== {exp_we, exp_addr, exp_wdata}) hold_bad = 1;
      end
      tests_run++;
      if (n !== exp_n || hold_bad !== 1'b0) begin
        tests_failed++; $display("FAIL rnd_busy[%0d]: got cycles=%0d hold_bad=%b required %0d 0", t, n, hold_bad, exp_n);
      end
      tests_run++;
      if ({cpu_ready, dma_ready, err} !== {!win_dma, win_dma, exp_to}) begin
        tests_failed++; $display("FAIL rnd_ready[%0d]: got cpu=%b dma=%b err=%b required %b %b %b", t, cpu_ready, dma_ready, err, !win_dma, win_dma, exp_to);
      end
      tests_run++;
      if ((win_dma ? {dma_rdata, cpu_rdata} : {cpu_rdata, dma_rdata}) !== {exp_rdata, 32'h0}) begin
        tests_failed++; $display("FAIL rnd_rdata[%0d]: got cpu=%h dma=%h required owner %h other 0", t, cpu_rdata, dma_rdata, exp_rdata);
      end
      if (win_dma) dma_pend = 0; else cpu_pend = 0;
      cpu_req = cpu_pend; dma_req = dma_pend;
    end
    cpu_req = 0; dma_req = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_fair_share();
    test_timeout();
    test_reset_busy();
    test_spurious_ack();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
